// File: rtl/memory_responder.sv
// Memory-side responder for the MAR/MDR datapath: word RAM behind a wait-state
// counter and a 4-phase ready handshake. Define MEM_WPROT_EN to write-protect low words.
module memory_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2,
  parameter int PROTECT_TOP = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       MAR_addr,
  input  logic [DATA_W-1:0] MDR_wdata,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PROT_IDX = ADDR_W'(PROTECT_TOP);
`ifdef MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rd, r_wr, r_bad;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ready, r_busy, r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_prot, w_bad, w_access;

  // With WPROT=0 the compare folds away entirely.
  assign w_prot   = WPROT && Write && !Read && (MAR_addr[ADDR_W-1:0] < PROT_IDX);
  assign w_bad    = (Read && Write) || (|MAR_addr[31:ADDR_W]) || w_prot;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0) && !r_bad;

  // RAM is never reset; a clear on the access edge aborts the write.
  always_ff @(posedge clock) begin
    if (w_access && r_wr && !clear) r_mem[r_addr] <= r_wdata;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (Read || Write) begin
          r_addr  <= MAR_addr[ADDR_W-1:0];
          r_wdata <= MDR_wdata;
          r_rd    <= Read;
          r_wr    <= Write;
          r_bad   <= w_bad;
          r_cnt   <= 4'(WAIT_CYCLES);
          r_busy  <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          if (w_access && r_rd) r_rdata <= r_mem[r_addr];
          r_err   <= r_bad;
          r_ready <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: if (!Read && !Write) begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Mdatain   = r_rdata;
  assign mem_ready = r_ready;
  assign mem_busy  = r_busy;
  assign mem_err   = r_err;
endmodule
